// File: rtl/vram_dp_sync.sv
// vram_dp_sync: single-clock true dual-port video/tile RAM.
//   Port A (pixel writer) and port B (scan-out / second client) each take one
//   access per cycle. Read data returns RD_LAT cycles after the accept cycle
//   with a valid strobe and an out-of-range flag. WRITE_MODE selects the
//   same-port read-during-write return (0 READ_FIRST, 1 WRITE_FIRST,
//   2 NO_CHANGE). When both ports write the same in-range word, port A wins.
//   Optional build macro VRAM_DP_CLEAR_EN adds clr_req/clr_busy and a fill
//   engine that writes CLEAR_VAL to every word, one word per cycle.
module vram_dp_sync #(
  parameter int                DATA_W     = 8,
  parameter int                DEPTH      = 57600,
  parameter int                ADDR_W     = 16,
  parameter int                RD_LAT     = 1,
  parameter int                WRITE_MODE = 0,
  parameter logic [DATA_W-1:0] CLEAR_VAL  = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_en,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_din,
  output logic [DATA_W-1:0] a_dout,
  output logic              a_valid,
  output logic              a_err,
  input  logic              b_en,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_din,
  output logic [DATA_W-1:0] b_dout,
  output logic              b_valid,
  output logic              b_err,
  output logic              collision
`ifdef VRAM_DP_CLEAR_EN
  ,
  input  logic              clr_req,
  output logic              clr_busy
`endif
);

  localparam int              IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic              busy;

  logic              a_acc, a_in, a_wr, a_ret;
  logic [IW-1:0]     a_idx;
  logic [DATA_W-1:0] a_rdata;
  logic              b_acc, b_in, b_wr_req, b_wr, b_ret;
  logic [IW-1:0]     b_idx;
  logic [DATA_W-1:0] b_rdata;
  logic              same_wr;

  // first pipeline stage (array output register)
  logic [DATA_W-1:0] a_d1, b_d1;
  logic              a_v1, a_e1, b_v1, b_e1;

`ifdef VRAM_DP_CLEAR_EN
  typedef enum logic {CLR_IDLE, CLR_SWEEP} clr_state_t;

  clr_state_t    clr_state;
  logic [IW-1:0] clr_cnt;
  logic          clr_wr;

  assign busy   = clr_busy;
  assign clr_wr = (clr_state == CLR_SWEEP);

  // Fill engine: one CLEAR_VAL word per cycle from address 0 to DEPTH-1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clr_state <= CLR_IDLE;
      clr_cnt   <= '0;
      clr_busy  <= 1'b0;
    end else begin
      case (clr_state)
        CLR_IDLE: begin
          if (clr_req) begin
            clr_state <= CLR_SWEEP;
            clr_cnt   <= '0;
            clr_busy  <= 1'b1;
          end
        end
        CLR_SWEEP: begin
          if (clr_cnt == IW'(DEPTH - 1)) begin
            clr_state <= CLR_IDLE;
            clr_busy  <= 1'b0;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        default: begin
          clr_state <= CLR_IDLE;
          clr_busy  <= 1'b0;
        end
      endcase
    end
  end
`else
  assign busy = 1'b0;
`endif

  // Port A accept, range check and same-port return selection
  always_comb begin
    a_acc   = a_en & ~rst & ~busy;
    a_in    = ({1'b0, a_addr} < DEPTH_L);
    a_idx   = a_addr[IW-1:0];
    a_wr    = a_acc & a_we & a_in;
    a_ret   = a_acc & (~a_we | (WRITE_MODE != 2));
    a_rdata = '0;
    if (a_in) begin
      if (a_we && (WRITE_MODE == 1)) a_rdata = a_din;
      else                           a_rdata = mem[a_idx];
    end
  end

  // Port B accept, range check and same-port return selection
  always_comb begin
    b_acc    = b_en & ~rst & ~busy;
    b_in     = ({1'b0, b_addr} < DEPTH_L);
    b_idx    = b_addr[IW-1:0];
    b_wr_req = b_acc & b_we & b_in;
    b_ret    = b_acc & (~b_we | (WRITE_MODE != 2));
    b_rdata  = '0;
    if (b_in) begin
      if (b_we && (WRITE_MODE == 1)) b_rdata = b_din;
      else                           b_rdata = mem[b_idx];
    end
  end

  // Port A has priority on a same-address double write; B's store is dropped
  always_comb begin
    same_wr = a_wr & b_wr_req & (a_addr == b_addr);
    b_wr    = b_wr_req & ~same_wr;
  end

  // Storage array: no reset, writes from both ports and the fill engine
  always_ff @(posedge clk) begin
    if (a_wr) mem[a_idx] <= a_din;
    if (b_wr) mem[b_idx] <= b_din;
`ifdef VRAM_DP_CLEAR_EN
    if (clr_wr) mem[clr_cnt] <= CLEAR_VAL;
`endif
  end

  // First read stage and collision flag; dout only updates on a return
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_d1      <= '0;
      a_v1      <= 1'b0;
      a_e1      <= 1'b0;
      b_d1      <= '0;
      b_v1      <= 1'b0;
      b_e1      <= 1'b0;
      collision <= 1'b0;
    end else begin
      a_v1      <= a_ret;
      a_e1      <= a_ret & ~a_in;
      b_v1      <= b_ret;
      b_e1      <= b_ret & ~b_in;
      collision <= same_wr;
      if (a_ret) a_d1 <= a_rdata;
      if (b_ret) b_d1 <= b_rdata;
    end
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic [DATA_W-1:0] a_d2, b_d2;
      logic              a_v2, a_e2, b_v2, b_e2;

      // Second read stage: dout, valid and err move together
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_d2 <= '0;
          a_v2 <= 1'b0;
          a_e2 <= 1'b0;
          b_d2 <= '0;
          b_v2 <= 1'b0;
          b_e2 <= 1'b0;
        end else begin
          a_v2 <= a_v1;
          a_e2 <= a_e1;
          b_v2 <= b_v1;
          b_e2 <= b_e1;
          if (a_v1) a_d2 <= a_d1;
          if (b_v1) b_d2 <= b_d1;
        end
      end

      assign a_dout  = a_d2;
      assign a_valid = a_v2;
      assign a_err   = a_e2;
      assign b_dout  = b_d2;
      assign b_valid = b_v2;
      assign b_err   = b_e2;
    end else begin : g_lat1
      assign a_dout  = a_d1;
      assign a_valid = a_v1;
      assign a_err   = a_e1;
      assign b_dout  = b_d1;
      assign b_valid = b_v1;
      assign b_err   = b_e1;
    end
  endgenerate

endmodule

// File: tb/tb_vram_dp_sync.sv
// tb_vram_dp_sync: directed checks of vram_dp_sync.
//   u0: RD_LAT=1 READ_FIRST, u1: WRITE_FIRST, u2: NO_CHANGE, u3: RD_LAT=2.
//   All four share one stimulus. With VRAM_DP_CLEAR_EN, u4 (DEPTH=16,
//   CLEAR_VAL=0xA5) exercises the fill engine.
module tb_vram_dp_sync;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_en, a_we, b_en, b_we;
  logic [15:0] a_addr, b_addr;
  logic [7:0]  a_din, b_din;

  logic [7:0]  a_dout [4];
  logic [7:0]  b_dout [4];
  logic        a_valid [4];
  logic        a_err [4];
  logic        b_valid [4];
  logic        b_err [4];
  logic        collision [4];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  vram_dp_sync #(.DATA_W(8), .DEPTH(57600), .ADDR_W(16), .RD_LAT(1), .WRITE_MODE(0)) u0 (
    .clk(clk), .rst(rst),
    .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_din(a_din),
    .a_dout(a_dout[0]), .a_valid(a_valid[0]), .a_err(a_err[0]),
    .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_din(b_din),
    .b_dout(b_dout[0]), .b_valid(b_valid[0]), .b_err(b_err[0]),
    .collision(collision[0])
`ifdef VRAM_DP_CLEAR_EN
    , .clr_req(1'b0), .clr_busy()
`endif
  );

  vram_dp_sync #(.DATA_W(8), .DEPTH(57600), .ADDR_W(16), .RD_LAT(1), .WRITE_MODE(1)) u1 (
    .clk(clk), .rst(rst),
    .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_din(a_din),
    .a_dout(a_dout[1]), .a_valid(a_valid[1]), .a_err(a_err[1]),
    .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_din(b_din),
    .b_dout(b_dout[1]), .b_valid(b_valid[1]), .b_err(b_err[1]),
    .collision(collision[1])
`ifdef VRAM_DP_CLEAR_EN
    , .clr_req(1'b0), .clr_busy()
`endif
  );

  vram_dp_sync #(.DATA_W(8), .DEPTH(57600), .ADDR_W(16), .RD_LAT(1), .WRITE_MODE(2)) u2 (
    .clk(clk), .rst(rst),
    .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_din(a_din),
    .a_dout(a_dout[2]), .a_valid(a_valid[2]), .a_err(a_err[2]),
    .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_din(b_din),
    .b_dout(b_dout[2]), .b_valid(b_valid[2]), .b_err(b_err[2]),
    .collision(collision[2])
`ifdef VRAM_DP_CLEAR_EN
    , .clr_req(1'b0), .clr_busy()
`endif
  );

  vram_dp_sync #(.DATA_W(8), .DEPTH(57600), .ADDR_W(16), .RD_LAT(2), .WRITE_MODE(0)) u3 (
    .clk(clk), .rst(rst),
    .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_din(a_din),
    .a_dout(a_dout[3]), .a_valid(a_valid[3]), .a_err(a_err[3]),
    .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_din(b_din),
    .b_dout(b_dout[3]), .b_valid(b_valid[3]), .b_err(b_err[3]),
    .collision(collision[3])
`ifdef VRAM_DP_CLEAR_EN
    , .clr_req(1'b0), .clr_busy()
`endif
  );

`ifdef VRAM_DP_CLEAR_EN
  logic        c_a_en, c_a_we, clr_req, clr_busy;
  logic [15:0] c_a_addr;
  logic [7:0]  c_a_din, c_a_dout, c_b_dout;
  logic        c_a_valid, c_a_err, c_b_valid, c_b_err, c_collision;

  vram_dp_sync #(.DATA_W(8), .DEPTH(16), .ADDR_W(16), .RD_LAT(1), .WRITE_MODE(0),
                 .CLEAR_VAL(8'hA5)) u4 (
    .clk(clk), .rst(rst),
    .a_en(c_a_en), .a_we(c_a_we), .a_addr(c_a_addr), .a_din(c_a_din),
    .a_dout(c_a_dout), .a_valid(c_a_valid), .a_err(c_a_err),
    .b_en(1'b0), .b_we(1'b0), .b_addr(16'h0000), .b_din(8'h00),
    .b_dout(c_b_dout), .b_valid(c_b_valid), .b_err(c_b_err),
    .collision(c_collision),
    .clr_req(clr_req), .clr_busy(clr_busy)
  );
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_en = 1'b0; a_we = 1'b0;
    b_en = 1'b0; b_we = 1'b0;
  endtask

  task automatic wr_a(input logic [15:0] ad, input logic [7:0] d);
    a_en = 1'b1; a_we = 1'b1; a_addr = ad; a_din = d;
  endtask

  task automatic rd_a(input logic [15:0] ad);
    a_en = 1'b1; a_we = 1'b0; a_addr = ad;
  endtask

  task automatic wr_b(input logic [15:0] ad, input logic [7:0] d);
    b_en = 1'b1; b_we = 1'b1; b_addr = ad; b_din = d;
  endtask

  task automatic rd_b(input logic [15:0] ad);
    b_en = 1'b1; b_we = 1'b0; b_addr = ad;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    idle();
    a_addr = '0; a_din = '0; b_addr = '0; b_din = '0;
`ifdef VRAM_DP_CLEAR_EN
    c_a_en = 1'b0; c_a_we = 1'b0; c_a_addr = '0; c_a_din = '0; clr_req = 1'b0;
`endif
    #12;
    // reset state
    chk("rst_a_valid", 32'(a_valid[0]), 0);
    chk("rst_a_dout",  32'(a_dout[0]), 0);
    chk("rst_a_err",   32'(a_err[0]), 0);
    chk("rst_b_valid", 32'(b_valid[0]), 0);
    chk("rst_b_dout",  32'(b_dout[0]), 0);
    chk("rst_coll",    32'(collision[0]), 0);
    chk("rst_l2_bval", 32'(b_valid[3]), 0);
    rst = 1'b0;

    // A write 0x5A @ 0x10
    wr_a(16'h0010, 8'h5A); cyc(); idle();
    chk("rf_wr_valid", 32'(a_valid[0]), 1);
    chk("wf_wr_valid", 32'(a_valid[1]), 1);
    chk("wf_wr_data",  32'(a_dout[1]), 32'h5A);
    chk("nc_wr_noval", 32'(a_valid[2]), 0);

    // B read 0x10 the following cycle
    rd_b(16'h0010); cyc(); idle();
    chk("b_rd_valid",  32'(b_valid[0]), 1);
    chk("b_rd_data",   32'(b_dout[0]), 32'h5A);
    chk("b_rd_err",    32'(b_err[0]), 0);
    chk("l2_not_yet",  32'(b_valid[3]), 0);
    cyc();
    chk("b_val_pulse", 32'(b_valid[0]), 0);
    chk("b_dout_hold", 32'(b_dout[0]), 32'h5A);
    chk("l2_valid",    32'(b_valid[3]), 1);
    chk("l2_data",     32'(b_dout[3]), 32'h5A);

    // both ports write 0x20 in the same cycle
    wr_a(16'h0020, 8'h11); wr_b(16'h0020, 8'h22); cyc(); idle();
    chk("coll_set",    32'(collision[0]), 1);
    chk("wf_a_own",    32'(a_dout[1]), 32'h11);
    chk("wf_b_own",    32'(b_dout[1]), 32'h22);
    chk("wf_b_valid",  32'(b_valid[1]), 1);
    rd_a(16'h0020); cyc(); idle();
    chk("coll_pulse",  32'(collision[0]), 0);
    chk("coll_a_wins", 32'(a_dout[0]), 32'h11);
    chk("coll_a_val",  32'(a_valid[0]), 1);
    chk("nc_rd_data",  32'(a_dout[2]), 32'h11);

    // A writes 0x30 while B reads 0x30 (prior value 0x00)
    wr_a(16'h0030, 8'h00); cyc();
    wr_a(16'h0030, 8'h33); rd_b(16'h0030); cyc(); idle();
    chk("xrd_old",     32'(b_dout[0]), 32'h00);
    chk("xrd_valid",   32'(b_valid[0]), 1);
    chk("rf_old_word", 32'(a_dout[0]), 32'h00);
    chk("wf_new_word", 32'(a_dout[1]), 32'h33);
    chk("nc_noval",    32'(a_valid[2]), 0);
    chk("nc_hold",     32'(a_dout[2]), 32'h11);
    rd_b(16'h0030); cyc(); idle();
    chk("xrd_new",     32'(b_dout[0]), 32'h33);

    // RD_LAT=2 back-to-back B reads of 0,1,2 (preloaded 7,8,9)
    wr_a(16'h0000, 8'h07); cyc();
    wr_a(16'h0001, 8'h08); cyc();
    wr_a(16'h0002, 8'h09); cyc(); idle(); cyc();
    rd_b(16'h0000); cyc();
    chk("l2_s0_val",   32'(b_valid[3]), 0);
    chk("l1_s0_data",  32'(b_dout[0]), 32'h07);
    rd_b(16'h0001); cyc();
    chk("l2_s1_val",   32'(b_valid[3]), 1);
    chk("l2_s1_data",  32'(b_dout[3]), 32'h07);
    rd_b(16'h0002); cyc(); idle();
    chk("l2_s2_val",   32'(b_valid[3]), 1);
    chk("l2_s2_data",  32'(b_dout[3]), 32'h08);
    cyc();
    chk("l2_s3_val",   32'(b_valid[3]), 1);
    chk("l2_s3_data",  32'(b_dout[3]), 32'h09);
    cyc();
    chk("l2_s4_val",   32'(b_valid[3]), 0);
    chk("l2_s4_hold",  32'(b_dout[3]), 32'h09);

    // reset asserted mid-stream flushes in-flight reads
    rd_b(16'h0000); cyc();
    rd_b(16'h0001); cyc();
    chk("rst_pre_val", 32'(b_valid[3]), 1);
    rd_b(16'h0002);
    #1 rst = 1'b1;
    #1;
    chk("rst_l2_val",  32'(b_valid[3]), 0);
    chk("rst_l2_dout", 32'(b_dout[3]), 0);
    chk("rst_l1_val",  32'(b_valid[0]), 0);
    idle();
    cyc(); cyc();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("post_rst_l2", 32'(b_valid[3]), 0);
      chk("post_rst_l1", 32'(b_valid[0]), 0);
    end

    // out-of-range read and write
    rd_a(16'd57600); cyc(); idle();
    chk("oor_rd_val",  32'(a_valid[0]), 1);
    chk("oor_rd_data", 32'(a_dout[0]), 0);
    chk("oor_rd_err",  32'(a_err[0]), 1);
    wr_a(16'd60000, 8'hFF); cyc(); idle();
    chk("oor_wr_val",  32'(a_valid[0]), 1);
    chk("oor_wr_data", 32'(a_dout[0]), 0);
    chk("oor_wr_err",  32'(a_err[0]), 1);
    chk("oor_wf_data", 32'(a_dout[1]), 0);
    chk("oor_nc_val",  32'(a_valid[2]), 0);
    rd_a(16'h0000); cyc(); idle();
    chk("after_oor",   32'(a_dout[0]), 32'h07);
    chk("after_err",   32'(a_err[0]), 0);
    // last in-range word
    wr_a(16'd57599, 8'h42); cyc();
    rd_a(16'd57599); cyc(); idle();
    chk("top_data",    32'(a_dout[0]), 32'h42);
    chk("top_err",     32'(a_err[0]), 0);

`ifdef VRAM_DP_CLEAR_EN
    begin
      int busy_cycles;
      int stray_valid;
      chk("clr_idle",  32'(clr_busy), 0);
      clr_req = 1'b1; cyc(); clr_req = 1'b0;
      chk("clr_start", 32'(clr_busy), 1);
      // hammer address 0 with writes for the whole sweep
      c_a_en = 1'b1; c_a_we = 1'b1; c_a_addr = 16'h0000; c_a_din = 8'h3C;
      busy_cycles = 1;
      stray_valid = 0;
      for (int k = 0; k < 40 && clr_busy; k++) begin
        cyc();
        if (c_a_valid) stray_valid++;
        if (clr_busy) busy_cycles++;
      end
      c_a_en = 1'b0; c_a_we = 1'b0;
      chk("clr_done",    32'(clr_busy), 0);
      chk("clr_cycles",  32'(busy_cycles), 16);
      chk("clr_novalid", 32'(stray_valid), 0);
      for (int i = 0; i < 16; i++) begin
        c_a_en = 1'b1; c_a_we = 1'b0; c_a_addr = 16'(i);
        cyc();
        chk("clr_word",  32'(c_a_dout), 32'hA5);
        chk("clr_valid", 32'(c_a_valid), 1);
      end
      c_a_en = 1'b0;
      cyc();
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vram_dp_sync.md
Name: vram_dp_sync

Overview:
Parametrised true dual-port frame/tile memory on a single clock domain; next generation of the project's 8-bit 57600-entry video RAM. Adds:
- configurable width, depth and read latency
- per-port read-valid strobe
- defined write modes and cross-port collision rules
- out-of-range address detection
Sits between the pixel writer (port A) and the display scan-out or second client (port B).

Parameters:
DATA_W, 8, data width in bits (>=1)
DEPTH, 57600, number of words; addresses >= DEPTH are out of range
ADDR_W, 16, address width; must satisfy 2^ADDR_W >= DEPTH
RD_LAT, 1, read latency in cycles; legal values 1 (array register only) or 2 (extra output register)
WRITE_MODE, 0, same-port read-during-write: 0 READ_FIRST, 1 WRITE_FIRST, 2 NO_CHANGE
CLEAR_VAL, 0, fill value for the clear engine (DATA_W bits)

Ports:
clk  in  1  single clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
a_en  in  1  port A access request this cycle
a_we  in  1  port A write (qualified by a_en)
a_addr  in  ADDR_W  port A address
a_din  in  DATA_W  port A write data
a_dout  out  DATA_W  port A read data
a_valid  out  1  a_dout valid, one-cycle pulse per returned read
a_err  out  1  out-of-range flag, aligned with a_valid
b_en, b_we, b_addr, b_din, b_dout, b_valid, b_err: same as port A, for port B
collision  out  1  one-cycle pulse, registered: both ports wrote the same in-range address the previous cycle
clr_req  in  1  (only with VRAM_DP_CLEAR_EN) start fill
clr_busy  out  1  (only with VRAM_DP_CLEAR_EN) fill in progress

Behaviour:
- Reset (asynchronous assert, released on clk):
  - all outputs go to 0; read pipelines flushed, so in-flight reads are lost and produce no valid
  - memory contents are not reset
  - no writes while rst=1
- Access: an accepted access has x_en=1, rst=0 and the clear engine idle.
  - Write: x_we=1 with an in-range address stores x_din at the clk edge.
  - Read: x_we=0 returns data with x_valid=1 exactly RD_LAT cycles after the accept cycle.
  - Throughput: one access per port per cycle, no stalls.
- Write and valid per WRITE_MODE:
  - READ_FIRST: a write also returns the old word with valid after RD_LAT cycles.
  - WRITE_FIRST: a write returns the new word with valid after RD_LAT cycles.
  - NO_CHANGE: a write produces no valid; x_dout holds its last value.
- x_dout holds its value between valid pulses (except reset).
- Cross-port, same in-range address, same cycle:
  - A writes, B reads: B gets the old word. B writes, A reads: same rule.
  - Both write: port A data stored, B data discarded; collision=1 the next cycle. The same-port return for each writer still follows WRITE_MODE using its own din.
  - Both read: both get the stored word.
- Out of range (addr >= DEPTH): write ignored; the access still returns x_dout=0, x_valid=1 (if the mode returns data for that access) and x_err=1 at the normal latency. x_err=0 on all in-range returns.
- RD_LAT=2: the second stage registers dout, valid and err together; the first stage is internal.

Optional Feature:
VRAM_DP_CLEAR_EN
- Defined: clr_req/clr_busy ports exist and a fill FSM is present.
  - IDLE: clr_req=1 -> SWEEP, counter=0, clr_busy=1 from the next cycle.
  - SWEEP: writes CLEAR_VAL to address counter, one word per cycle, for DEPTH cycles; after address DEPTH-1 -> IDLE, clr_busy=0. Full fill takes DEPTH cycles.
  - While busy, port accesses are ignored (no write, no valid) and clr_req is ignored.
  - Read results already in the pipeline when the fill starts still emerge.
  - Reset mid-sweep: FSM goes to IDLE, fill is left partial.
- Undefined: no ports, no FSM; memory is only written through A/B.

Test Plan:
- RD_LAT=1, READ_FIRST: A write 0x5A@0x0010, next cycle B read 0x0010 -> b_valid 1 cycle later, b_dout=0x5A, b_err=0.
- Same cycle: A write 0x11@0x20, B write 0x22@0x20; then A read 0x20 -> collision=1 the cycle after the writes; read returns 0x11.
- A write 0x33@0x30 while B reads 0x30 (prior 0x00) -> b_dout=0x00; a follow-up B read -> 0x33. Repeat with WRITE_MODE=1 -> a_dout=0x33 on the write; WRITE_MODE=2 -> no a_valid.
- RD_LAT=2: back-to-back B reads of 0,1,2 (preloaded 7,8,9) -> b_valid high 3 consecutive cycles starting 2 cycles after the first read, data 7,8,9. Assert rst mid-stream -> b_valid=0 immediately, no further pulses.
- A read 57600 and A write 0xFF@60000 -> a_valid with a_dout=0, a_err=1; a later read of 0 is unchanged.
- VRAM_DP_CLEAR_EN, DEPTH=16, CLEAR_VAL=0xA5: clr_req pulse -> clr_busy high 16 cycles; port A write during busy is ignored; afterwards all 16 words read 0xA5.
